// File: rtl/tm_feedback_sched.sv
// Per-sample Tsetlin feedback scheduler: computes d from (v, q, T) and issues Type I/II commands per clause.
// Build option TM_SKIP_UNSELECTED_EN: clauses with fb_en=0 are skipped internally instead of presented.
//
// state  | meaning
// IDLE   | waiting for start, inputs latched on accept
// CALC1  | clip score, register |err|
// CALC2  | register d_out = |err| >> 1, reset clause index
// ISSUE  | present one feedback command per clause over valid/ready
// DONE   | one-cycle done pulse, return to IDLE
module tm_feedback_sched #(
    parameter int          T_WIDTH     = 8,
    parameter int          NUM_CLAUSES = 16,
    parameter int          CIDX_W      = 4,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [T_WIDTH:0]   T,
    input  logic               q,
    input  logic [T_WIDTH:0]   v,
    output logic               busy,
    output logic [T_WIDTH-1:0] d_out,
    output logic               fb_valid,
    input  logic               fb_ready,
    output logic [CIDX_W-1:0]  fb_idx,
    output logic               fb_type,
    output logic               fb_en,
    output logic               done
);

    localparam int EW = T_WIDTH + 2;

    typedef enum logic [2:0] {S_IDLE, S_CALC1, S_CALC2, S_ISSUE, S_DONE} state_t;

    state_t state, state_nx;

    logic [T_WIDTH:0]  t_reg;
    logic              q_reg;
    logic [T_WIDTH:0]  v_reg;
    logic [T_WIDTH:0]  abs_err;
    logic [CIDX_W-1:0] idx;
    logic [15:0]       lfsr;
    logic [15:0]       lfsr_nx;
    logic              sel;
    logic              last;
    logic              advance;

    logic signed [EW-1:0] t_s, v_s, clipped, err;

    // One extra bit of headroom keeps -T - clip(v) representable.
    assign t_s = {1'b0, t_reg};
    assign v_s = {v_reg[T_WIDTH], v_reg};

    always_comb begin
        if (v_s > t_s)
            clipped = t_s;
        else if (v_s < -t_s)
            clipped = -t_s;
        else
            clipped = v_s;
        err = q_reg ? (t_s - clipped) : (-t_s - clipped);
    end

    assign sel     = lfsr[T_WIDTH-1:0] < d_out;
    assign last    = idx == CIDX_W'(NUM_CLAUSES - 1);
    assign lfsr_nx = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        fb_valid = 1'b0;
        advance  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start)
                    state_nx = S_CALC1;
            end
            S_CALC1: begin
                busy     = 1'b1;
                state_nx = S_CALC2;
            end
            S_CALC2: begin
                busy     = 1'b1;
                state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                busy = 1'b1;
`ifdef TM_SKIP_UNSELECTED_EN
                fb_valid = sel;
                advance  = sel ? fb_ready : 1'b1;
`else
                fb_valid = 1'b1;
                advance  = fb_ready;
`endif
                if (advance && last)
                    state_nx = S_DONE;
            end
            S_DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Even clauses are positive polarity, so Type II exactly when q and polarity differ.
    assign fb_idx  = fb_valid ? idx : '0;
    assign fb_type = fb_valid & (q_reg ^ ~idx[0]);
    assign fb_en   = fb_valid & sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_reg   <= '0;
            q_reg   <= 1'b0;
            v_reg   <= '0;
            abs_err <= '0;
            d_out   <= '0;
            idx     <= '0;
            lfsr    <= LFSR_SEED;
        end else begin
            if (state == S_IDLE && start) begin
                t_reg <= T;
                q_reg <= q;
                v_reg <= v;
            end
            if (state == S_CALC1)
                abs_err <= err[EW-1] ? (T_WIDTH+1)'(-err) : (T_WIDTH+1)'(err);
            if (state == S_CALC2) begin
                d_out <= T_WIDTH'(abs_err >> 1);
                idx   <= '0;
            end
            if (advance) begin
                lfsr <= lfsr_nx;
                idx  <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tm_feedback_sched.sv
// Scoreboard bench for tm_feedback_sched: stimulus pushes expected commands, a negedge monitor pops and compares.
module tb_tm_feedback_sched;

    localparam int          TW   = 8;
    localparam int          NC   = 4;
    localparam int          CW   = 2;
    localparam logic [15:0] SEED = 16'hACE1;
`ifdef TM_SKIP_UNSELECTED_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [TW:0]          t_in = '0;
    logic                 q_in = 1'b0;
    logic signed [TW:0]   v_in = '0;
    logic                 busy;
    logic [TW-1:0]        d_out;
    logic                 fb_valid;
    logic                 fb_ready = 1'b1;
    logic [CW-1:0]        fb_idx;
    logic                 fb_type;
    logic                 fb_en;
    logic                 done;

    tm_feedback_sched #(.T_WIDTH(TW), .NUM_CLAUSES(NC), .CIDX_W(CW), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .T(t_in), .q(q_in), .v(v_in),
        .busy(busy), .d_out(d_out), .fb_valid(fb_valid), .fb_ready(fb_ready),
        .fb_idx(fb_idx), .fb_type(fb_type), .fb_en(fb_en), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] idx;
        logic          typ;
        logic          en;
    } cmd_t;

    cmd_t        sb_q[$];
    logic [15:0] m_lfsr = SEED;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    task automatic push_pass(input logic qq, input logic [TW-1:0] d);
        for (int i = 0; i < NC; i++) begin
            cmd_t c;
            c.idx = CW'(i);
            c.typ = (qq == (i % 2 == 0)) ? 1'b0 : 1'b1;
            c.en  = m_lfsr[TW-1:0] < d;
            if (!SKIP || c.en)
                sb_q.push_back(c);
            m_lfsr = lfsr_step(m_lfsr);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && fb_valid && fb_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_cmd", {fb_idx, fb_type, fb_en}, 0);
            end else begin
                cmd_t e;
                e = sb_q.pop_front();
                chk("fb_idx", fb_idx, e.idx);
                chk("fb_type", fb_type, e.typ);
                chk("fb_en", fb_en, e.en);
            end
        end
    end

    // mode 0: plain pass, 1: 5-cycle stall on idx 1, 2: start pulsed during ISSUE
    task automatic run_pass(input logic [TW:0] tt, input logic qq, input logic signed [TW:0] vv,
                            input logic [TW-1:0] exp_d, input int mode);
        int       edges;
        bit       stalled;
        bit       hit_done;
        logic [CW+1:0] h;
        push_pass(qq, exp_d);
        t_in = tt; q_in = qq; v_in = vv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 0; stalled = 0; hit_done = 0;
        chk("busy_on_accept", busy, 1);
        while (edges < 200 && !hit_done) begin
            @(posedge clk); #1;
            edges++;
            start = (mode == 2 && edges == 3);
            if (mode == 2 && edges == 3) begin
                t_in = 9'd100; v_in = 9'sd0;
            end
            if (edges == 2)
                chk("d_out", d_out, exp_d);
            if (done) begin
                hit_done = 1;
            end else if (mode == 1 && !stalled && fb_valid && (SKIP || fb_idx == CW'(1))) begin
                stalled = 1;
                fb_ready = 1'b0;
                h = {fb_idx, fb_type, fb_en};
                for (int k = 0; k < 5; k++) begin
                    @(posedge clk); #1;
                    edges++;
                    chk("bp_hold", {fb_valid, fb_idx, fb_type, fb_en}, {1'b1, h});
                end
                fb_ready = 1'b1;
            end
        end
        start = 1'b0;
        if (mode == 1 && !SKIP)
            chk("bp_stall_taken", stalled, 1);
        chk("done_latency", edges, stalled ? 11 : 6);
        @(posedge clk); #1;
        chk("done_one_cycle", {done, busy}, 0);
        chk("sb_drained", sb_q.size(), 0);
        if (mode == 1)
            chk("lfsr_after_stall", dut.lfsr, m_lfsr);
        if (mode == 2) begin
            for (int k = 0; k < 4; k++) begin
                @(posedge clk); #1;
                chk("no_second_pass", {busy, fb_valid, done}, 0);
            end
            chk("d_out_held", d_out, exp_d);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", {busy, done, fb_valid, fb_idx, fb_type, fb_en, d_out}, 0);
        chk("rst_lfsr", dut.lfsr, SEED);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // v at +T with q=1: zero error, nothing selected
        run_pass(9'd36, 1'b1, 9'sd36, 8'd0, 0);
        // v clips to -36: err 72, d 36
        run_pass(9'd36, 1'b1, -9'sd100, 8'd36, 0);
        // q=0, v=10: err -46, d 23, types 1,0,1,0
        run_pass(9'd36, 1'b0, 9'sd10, 8'd23, 0);
        run_pass(9'd36, 1'b1, -9'sd100, 8'd36, 1);
        run_pass(9'd36, 1'b0, 9'sd10, 8'd23, 2);

        // abort mid-pass with reset at idx 2
        push_pass(1'b1, 8'd36);
        t_in = 9'd36; q_in = 1'b1; v_in = -9'sd100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        if (!SKIP)
            chk("pre_reset_idx", {fb_valid, fb_idx}, {1'b1, CW'(2)});
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {busy, done, fb_valid, fb_idx, fb_type, fb_en, d_out}, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("abort_no_done", {done, busy}, 0);
        end
        sb_q.delete();
        m_lfsr = SEED;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_pass(9'd36, 1'b1, -9'sd100, 8'd36, 0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
